// File: rtl/loop_mux.sv
// Registered loop-instruction operand decoder: selects one loop descriptor by address,
// splits it into iteration count / jump amount and attaches loop flags and name.
module loop_mux #(
   parameter int LOG_LOOP_CNT = 3,
   parameter int LOOP_CNT     = 1 << LOG_LOOP_CNT,
   parameter int ITER_W       = 18,
   parameter int JUMP_W       = 6
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 in_valid,
   input  logic [LOG_LOOP_CNT-1:0]              addr,
   input  logic [(ITER_W+JUMP_W)*LOOP_CNT-1:0]  in,
   input  logic                                 independent,
   input  logic                                 new_loop,
   output logic                                 out_valid,
   output logic                                 is_new_loop,
   output logic                                 is_independent,
   output logic [ITER_W-1:0]                    iteration_count,
   output logic [JUMP_W-1:0]                    jump_amount,
   output logic [LOG_LOOP_CNT-1:0]              name,
   output logic                                 zero_iter_error
);
   localparam int DESC_W = ITER_W + JUMP_W;

   logic [DESC_W-1:0] desc_arr [LOOP_CNT];
   logic [DESC_W-1:0] desc;

   for (genvar k = 0; k < LOOP_CNT; k++) begin : g_desc
      assign desc_arr[k] = in[k*DESC_W +: DESC_W];
   end

   always_comb desc = desc_arr[addr];

   logic                    valid_d, valid_q;
   logic                    new_d, new_q;
   logic                    indep_d, indep_q;
   logic [ITER_W-1:0]       iter_d, iter_q;
   logic [JUMP_W-1:0]       jump_d, jump_q;
   logic [LOG_LOOP_CNT-1:0] name_d, name_q;
   logic                    zerr_d, zerr_q;

   // Data fields hold between strobes; only the valid pulse follows in_valid.
   always_comb begin
      valid_d = in_valid;
      new_d   = new_q;
      indep_d = indep_q;
      iter_d  = iter_q;
      jump_d  = jump_q;
      name_d  = name_q;
      zerr_d  = zerr_q;
      if (in_valid) begin
         new_d   = new_loop;
         indep_d = independent & new_loop;
         iter_d  = desc[ITER_W-1:0];
         jump_d  = desc[DESC_W-1:ITER_W];
         name_d  = addr;
         zerr_d  = new_loop & (desc[ITER_W-1:0] == '0);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
         new_q   <= 1'b0;
         indep_q <= 1'b0;
         iter_q  <= '0;
         jump_q  <= '0;
         name_q  <= '0;
         zerr_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         new_q   <= new_d;
         indep_q <= indep_d;
         iter_q  <= iter_d;
         jump_q  <= jump_d;
         name_q  <= name_d;
         zerr_q  <= zerr_d;
      end
   end

   assign out_valid       = valid_q;
   assign is_new_loop     = new_q;
   assign is_independent  = indep_q;
   assign iteration_count = iter_q;
   assign jump_amount     = jump_q;
   assign name            = name_q;
   assign zero_iter_error = zerr_q;
endmodule

// File: tb/tb_loop_mux.sv
// Bench for loop_mux: vector table plus scoreboard queue, with reset corner sequences.
module tb_loop_mux;
   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         in_valid = 1'b0;
   logic [2:0]   addr = '0;
   logic [191:0] din = '0;
   logic         independent = 1'b0;
   logic         new_loop = 1'b0;
   logic         out_valid, is_new_loop, is_independent, zero_iter_error;
   logic [17:0]  iteration_count;
   logic [5:0]   jump_amount;
   logic [2:0]   name;

   loop_mux dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .addr(addr), .in(din),
      .independent(independent), .new_loop(new_loop), .out_valid(out_valid),
      .is_new_loop(is_new_loop), .is_independent(is_independent),
      .iteration_count(iteration_count), .jump_amount(jump_amount),
      .name(name), .zero_iter_error(zero_iter_error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [17:0] iter;
      logic [5:0]  jump;
      logic [2:0]  nm;
      logic        isnew;
      logic        isind;
      logic        zerr;
   } exp_t;

   typedef struct {
      logic [2:0]   a;
      logic         nl;
      logic         ind;
      logic [191:0] d;
      exp_t         e;
   } vec_t;

   exp_t   sb[$];
   exp_t   last_e;
   vec_t   vecs[7];
   int     n_chk = 0;
   int     n_fail = 0;
   logic [191:0] base;
   logic [191:0] sweep;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " out_valid"}, 32'(out_valid), 0);
      chk({tag, " data"}, {3'b0, is_new_loop, is_independent, zero_iter_error, name, iteration_count, jump_amount}, 0);
   endtask

   task automatic chk_fields(input string tag, input exp_t e);
      chk({tag, " iteration_count"}, 32'(iteration_count), 32'(e.iter));
      chk({tag, " jump_amount"}, 32'(jump_amount), 32'(e.jump));
      chk({tag, " name"}, 32'(name), 32'(e.nm));
      chk({tag, " is_new_loop"}, 32'(is_new_loop), 32'(e.isnew));
      chk({tag, " is_independent"}, 32'(is_independent), 32'(e.isind));
      chk({tag, " zero_iter_error"}, 32'(zero_iter_error), 32'(e.zerr));
   endtask

   // Drive one strobe at negedge, push its expectation, compare after the next rising edge.
   task automatic apply(input string tag, input vec_t v);
      exp_t e;
      @(negedge clk);
      din = v.d; addr = v.a; new_loop = v.nl; independent = v.ind; in_valid = 1'b1;
      sb.push_back(v.e);
      @(posedge clk); #1;
      chk({tag, " out_valid"}, 32'(out_valid), 1);
      if (sb.size() == 0) begin
         n_chk++; n_fail++;
         $display("FAIL %s scoreboard: got empty queue expected entry", tag);
      end else begin
         e = sb.pop_front();
         chk_fields(tag, e);
         last_e = e;
      end
   endtask

   task automatic hold_check(input string tag);
      @(negedge clk);
      in_valid = 1'b0; din = {6{$urandom}}; addr = 3'($urandom);
      new_loop = ~new_loop; independent = ~independent;
      @(posedge clk); #1;
      chk({tag, " out_valid"}, 32'(out_valid), 0);
      chk_fields(tag, last_e);
   endtask

   initial begin
      base = {6{32'h5A5A_1234}};
      base[72 +: 24]  = {6'd5, 18'd100};
      base[168 +: 24] = {6'h3F, 18'h3FFFF};
      base[0 +: 24]   = {6'd1, 18'd0};
      base[120 +: 24] = {6'd9, 18'd777};
      for (int k = 0; k < 8; k++) sweep[k*24 +: 24] = {6'(k), 18'(k*1000+1)};

      vecs[0] = '{3'd3, 1'b1, 1'b1, base, '{18'd100, 6'd5, 3'd3, 1'b1, 1'b1, 1'b0}};
      vecs[1] = '{3'd3, 1'b0, 1'b1, base, '{18'd100, 6'd5, 3'd3, 1'b0, 1'b0, 1'b0}};
      vecs[2] = '{3'd7, 1'b1, 1'b0, base, '{18'h3FFFF, 6'd63, 3'd7, 1'b1, 1'b0, 1'b0}};
      vecs[3] = '{3'd0, 1'b1, 1'b0, base, '{18'd0, 6'd1, 3'd0, 1'b1, 1'b0, 1'b1}};
      vecs[4] = '{3'd3, 1'b1, 1'b0, base, '{18'd100, 6'd5, 3'd3, 1'b1, 1'b0, 1'b0}};
      vecs[5] = '{3'd0, 1'b0, 1'b1, base, '{18'd0, 6'd1, 3'd0, 1'b0, 1'b0, 1'b0}};
      vecs[6] = '{3'd0, 1'b1, 1'b1, base, '{18'd0, 6'd1, 3'd0, 1'b1, 1'b1, 1'b1}};

      // Reset asserted with live strobes: outputs stay zero.
      #1 reset = 1'b1;
      #1 chk_zero("reset async");
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         din = {6{$urandom}}; addr = 3'($urandom); new_loop = 1'b1; independent = 1'b1; in_valid = 1'b1;
         @(posedge clk); #1;
         chk_zero("reset held");
      end
      @(negedge clk);
      reset = 1'b0; in_valid = 1'b0;
      @(posedge clk); #1;
      chk_zero("post reset idle");

      // Single strobe then hold.
      apply("desc3 start", vecs[0]);
      hold_check("desc3 hold");

      // Back-to-back table.
      for (int i = 1; i < 7; i++) apply($sformatf("vec%0d", i), vecs[i]);
      hold_check("table hold");

      // Sweep all descriptors back-to-back.
      for (int k = 0; k < 8; k++) begin
         vec_t v;
         v.a = 3'(k); v.nl = 1'b1; v.ind = k[0]; v.d = sweep;
         v.e = '{18'(k*1000+1), 6'(k), 3'(k), 1'b1, k[0], 1'b0};
         apply($sformatf("sweep%0d", k), v);
      end

      // Reset between strobe and output edge: strobe is discarded.
      @(negedge clk);
      din = base; addr = 3'd5; new_loop = 1'b1; independent = 1'b1; in_valid = 1'b1;
      #2 reset = 1'b1;
      #1 chk_zero("midreset async");
      @(posedge clk); #1;
      chk_zero("midreset edge");
      @(negedge clk);
      reset = 1'b0; in_valid = 1'b0;
      @(posedge clk); #1;
      chk("midreset no pulse", 32'(out_valid), 0);
      apply("after reset", '{3'd5, 1'b1, 1'b1, base, '{18'd777, 6'd9, 3'd5, 1'b1, 1'b1, 1'b0}});
      hold_check("after reset hold");

      chk("scoreboard drained", 32'(sb.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
